normalizador: RTL and testbench
===============================

NORMALIZADOR -- requirements
Module: normalizador

Interface
REQ-001 SHALL have parameter W, default 8, data width; legal values are powers of two from 4 to 32.
REQ-002 SHALL have derived localparam SW, equal to log2(W), which sets the shift-amount width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: din holds a value to normalize.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts din this cycle.
REQ-007 SHALL have port din, input, W bits: value to normalize.
REQ-008 SHALL have port out_valid, output, 1 bit: A, sh and zero are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream barrel left shifter consumes the result this cycle.
REQ-010 SHALL have port A, output, W bits: captured din, unmodified, to be shifted downstream.
REQ-011 SHALL have port sh, output, SW bits: leading-zero count of A; A shifted left by sh has its MSB set.
REQ-012 SHALL have port zero, output, 1 bit: the captured din was all zeros.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, COUNT and DONE.
REQ-014 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-015 IDLE, in_valid=1: SHALL capture din into A and into an internal scan register, clear the count, and go to COUNT if din≠0, else DONE with zero=1 and sh=0.
REQ-016 COUNT: SHALL go to DONE without change if scan MSB=1; otherwise shift scan left by 1 and increment the count, one bit per cycle.
REQ-017 Latency SHALL be, from the accept edge, lz+2 cycles to out_valid for nonzero din (lz = leading zeros) and 1 cycle for din=0; maximum is W+1.
REQ-018 DONE SHALL hold A, sh and zero stable until out_valid&&out_ready, then go to IDLE.
REQ-019 in_ready SHALL be 0 in DONE, even on the handshake cycle; the next input is accepted in IDLE at the earliest, giving no back-to-back throughput.
REQ-020 The count SHALL never wrap: a nonzero din terminates COUNT with sh ≤ W-1.
REQ-021 in_valid and din SHALL be ignored outside IDLE.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 A and sh SHALL retain their last values after the handshake until the next capture.

Reset
REQ-024 rst=1 at a clock edge SHALL force state=IDLE, A=0, sh=0, zero=0, out_valid=0, in_ready=1 after that edge.
REQ-025 rst SHALL take priority over every other event, including mid-COUNT or in DONE with out_ready=1; the in-flight result is discarded.

Configuration
REQ-026 With NORMALIZADOR_EXP_EN defined, SHALL add output port exp, SW bits, equal to W-1-sh: the bit index of the MSB one of A. It SHALL be valid with out_valid, forced to 0 when zero=1, and reset to 0.
REQ-027 Without NORMALIZADOR_EXP_EN, the exp port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 A shared package/include SHALL hold the FSM state encodings (IDLE, COUNT, DONE) and the default width constant, for reuse by the deslocamento integration top.
REQ-029 A sub-module is natural: normalizador_ctrl, holding the FSM and handshake; the datapath (capture, scan, count) stays in normalizador.

Verification (W=8)
REQ-030 din=8'h80, in_valid 1 cycle, out_ready=1 -> out_valid 2 cycles after accept; A=80, sh=0, zero=0, exp=7.
REQ-031 din=8'h01 -> out_valid 9 cycles after accept; A=01, sh=7, zero=0, exp=0.
REQ-032 din=8'h00 -> out_valid 1 cycle after accept; sh=0, zero=1, exp=0.
REQ-033 din=8'h14, out_ready held 0 for 5 cycles in DONE, din changed meanwhile -> A=14, sh=3 stable throughout; in_ready=0 until the cycle after out_ready=1.
REQ-034 rst pulsed in the third COUNT cycle of din=8'h02 -> the next cycle shows IDLE, in_ready=1, out_valid=0, A=0, sh=0; a subsequent din=8'h40 yields sh=1.

Source files
------------

// File: rtl/normalizador_pkg.sv
// Shared definitions for the leading-zero normalizer and its integration top.
// Holds the FSM state encodings and the default data width.
package normalizador_pkg;

    localparam int NORM_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

endpackage

// File: rtl/normalizador_if.sv
// Valid/ready handshake bundle between the upstream source, the normalizer and the barrel shifter.
// The exp field exists only when NORMALIZADOR_EXP_EN is defined.
interface normalizador_if
    import normalizador_pkg::*;
#(
    parameter int W = NORM_W_DEFAULT
) ();
    localparam int SW = $clog2(W);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  din;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  A;
    logic [SW-1:0] sh;
    logic          zero;
`ifdef NORMALIZADOR_EXP_EN
    logic [SW-1:0] exp;
`endif

    modport master (
`ifdef NORMALIZADOR_EXP_EN
        input  exp,
`endif
        output in_valid, din, out_ready,
        input  in_ready, out_valid, A, sh, zero
    );

    modport slave (
`ifdef NORMALIZADOR_EXP_EN
        output exp,
`endif
        input  in_valid, din, out_ready,
        output in_ready, out_valid, A, sh, zero
    );

endinterface

// File: rtl/normalizador_ctrl.sv
// Sequencing FSM and handshake for the normalizer; the datapath lives in the top.
//   state | meaning
//   IDLE  | in_ready=1, waiting for in_valid to capture din
//   COUNT | scanning one bit per cycle until the scan MSB is set
//   DONE  | out_valid=1, result held until out_ready
module normalizador_ctrl
    import normalizador_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid_i,
    input  logic din_zero_i,
    input  logic scan_msb_i,
    input  logic out_ready_i,
    output logic in_ready_o,
    output logic out_valid_o,
    output logic accept_o,
    output logic shift_o
);

    norm_state_t state_q;
    logic        in_ready_q;
    logic        out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        in_ready_q <= 1'b0;
                        if (din_zero_i) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (scan_msb_i) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign accept_o    = in_ready_q && in_valid_i;
    assign shift_o     = (state_q == COUNT) && !scan_msb_i;

endmodule

// File: rtl/normalizador.sv
// Leading-zero normalizer: captures din, counts leading zeros one bit per cycle for a barrel shifter.
// Optional exp output (MSB-one index) is built when NORMALIZADOR_EXP_EN is defined.
module normalizador
    import normalizador_pkg::*;
#(
    parameter int W = NORM_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    normalizador_if.slave  bus
);

    localparam int SW = $clog2(W);

    logic          accept;
    logic          shift;
    logic          din_zero;

    logic [W-1:0]  a_q,    a_d;
    logic [W-1:0]  scan_q, scan_d;
    logic [SW-1:0] cnt_q,  cnt_d;
    logic          zero_q, zero_d;

    assign din_zero = (bus.din == '0);

    normalizador_ctrl u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.in_valid),
        .din_zero_i  (din_zero),
        .scan_msb_i  (scan_q[W-1]),
        .out_ready_i (bus.out_ready),
        .in_ready_o  (bus.in_ready),
        .out_valid_o (bus.out_valid),
        .accept_o    (accept),
        .shift_o     (shift)
    );

    // The scan only shifts while its MSB is clear, so a nonzero value stops the count at W-1.
    always_comb begin
        a_d    = a_q;
        scan_d = scan_q;
        cnt_d  = cnt_q;
        zero_d = zero_q;
        if (accept) begin
            a_d    = bus.din;
            scan_d = bus.din;
            cnt_d  = '0;
            zero_d = din_zero;
        end else if (shift) begin
            scan_d = {scan_q[W-2:0], 1'b0};
            cnt_d  = cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            scan_q <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            scan_q <= scan_d;
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign bus.A    = a_q;
    assign bus.sh   = cnt_q;
    assign bus.zero = zero_q;

`ifdef NORMALIZADOR_EXP_EN
    logic [SW-1:0] exp_q, exp_d;

    // Counts down from W-1 in lockstep with the leading-zero count.
    always_comb begin
        exp_d = exp_q;
        if (accept) begin
            exp_d = din_zero ? '0 : SW'(W - 1);
        end else if (shift) begin
            exp_d = exp_q - SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= '0;
        end else begin
            exp_q <= exp_d;
        end
    end

    assign bus.exp = exp_q;
`endif

endmodule

// File: tb/tb_normalizador.sv
// Self-checking bench for normalizador at W=8: directed table, corner sequences and random vectors.
module tb_normalizador;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    normalizador_if #(.W(W)) bus ();

    normalizador #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        int         hold;
        int         sh;
        logic       zero;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lz_model(input logic [7:0] d);
        for (int i = W - 1; i >= 0; i--) begin
            if (d[i]) return W - 1 - i;
        end
        return 0;
    endfunction

    task automatic check_exp(input string name, input int e_sh, input logic e_zero);
`ifdef NORMALIZADOR_EXP_EN
        chk(name, 32'(bus.exp), e_zero ? 32'd0 : 32'(W - 1 - e_sh));
`else
        if (e_zero && e_sh < 0) $display("%s", name);
`endif
    endtask

    task automatic run_vec(input string tag, input logic [7:0] d, input int hold,
                           input int e_sh, input logic e_zero, input int e_lat);
        int  k;
        bit  stable;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.din       = d;
        bus.out_ready = 1'($urandom);
        step();
        k = 1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'($urandom);
        bus.din       = 8'($urandom);
        while (!bus.out_valid && k < W + 4) begin
            step();
            k++;
            bus.in_valid = 1'($urandom);
            bus.din      = 8'($urandom);
        end
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_latency"}, 32'(k), 32'(e_lat));
        chk({tag, "_A"}, 32'(bus.A), 32'(d));
        chk({tag, "_sh"}, 32'(bus.sh), 32'(e_sh));
        chk({tag, "_zero"}, 32'(bus.zero), 32'(e_zero));
        check_exp({tag, "_exp"}, e_sh, e_zero);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            bus.in_valid = 1'($urandom);
            bus.din      = 8'($urandom);
            if (bus.A !== d || 32'(bus.sh) !== 32'(e_sh) || bus.zero !== e_zero ||
                bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
        chk({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_post_A"}, 32'(bus.A), 32'(d));
        chk({tag, "_post_sh"}, 32'(bus.sh), 32'(e_sh));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_A"}, 32'(bus.A), 32'd0);
        chk({tag, "_sh"}, 32'(bus.sh), 32'd0);
        chk({tag, "_zero"}, 32'(bus.zero), 32'd0);
        check_exp({tag, "_exp"}, 0, 1'b1);
    endtask

    initial begin
        vec_t vecs[8];
        logic [7:0] d;
        int lz;

        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{din: 8'h80, hold: 0, sh: 0, zero: 1'b0, lat: 2};
        vecs[1] = '{din: 8'h01, hold: 1, sh: 7, zero: 1'b0, lat: 9};
        vecs[2] = '{din: 8'h00, hold: 0, sh: 0, zero: 1'b1, lat: 1};
        vecs[3] = '{din: 8'h14, hold: 5, sh: 3, zero: 1'b0, lat: 5};
        vecs[4] = '{din: 8'h40, hold: 2, sh: 1, zero: 1'b0, lat: 3};
        vecs[5] = '{din: 8'hFF, hold: 0, sh: 0, zero: 1'b0, lat: 2};
        vecs[6] = '{din: 8'h0F, hold: 3, sh: 4, zero: 1'b0, lat: 6};
        vecs[7] = '{din: 8'h00, hold: 4, sh: 0, zero: 1'b1, lat: 1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset_state("reset");

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].din, vecs[i].hold,
                    vecs[i].sh, vecs[i].zero, vecs[i].lat);
        end

        // Reset in the third COUNT cycle of 0x02 discards the scan.
        bus.in_valid = 1'b1;
        bus.din      = 8'h02;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("mid_count_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("rst_count");
        run_vec("after_rst", 8'h40, 1, 1, 1'b0, 3);

        // Reset wins over a DONE handshake.
        bus.in_valid = 1'b1;
        bus.din      = 8'h00;
        step();
        bus.in_valid = 1'b0;
        chk("rst_done_pre_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        step();
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        check_reset_state("rst_done");

        for (int i = 0; i < 40; i++) begin
            d  = 8'($urandom);
            if (i % 5 == 0) d = d >> $urandom_range(7, 0);
            lz = lz_model(d);
            run_vec($sformatf("rnd%0d", i), d, $urandom_range(3, 0), lz, (d == 8'h00),
                    (d == 8'h00) ? 1 : lz + 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
